aidan_mcnay_prime_seq: RTL and testbench



---
 rtl/aidan_mcnay_prime_seq.sv | 102 ++++++++++
 tb/tb_aidan_mcnay_prime_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_prime_seq.sv
// Trial-division primality sequencer: drives candidate/divisor pairs into an external
// remainder unit and reports a one-bit verdict per accepted number.
module aidan_mcnay_prime_seq #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] num,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_req_val,
  input  logic             div_req_rdy,
  input  logic [nbits-1:0] div_result,
  input  logic             div_resp_val,
  output logic             div_resp_rdy,
  output logic             is_prime,
  output logic             ostream_val,
  input  logic             ostream_rdy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [nbits-1:0] n_reg;
  logic [nbits-1:0] d_reg;
  logic [nbits:0]   sq_reg;

  // sq_reg tracks d_reg^2; (d+1)^2 = d^2 + 2d + 1 avoids a multiplier.
  logic [nbits:0] sq_next;
  logic [nbits:0] n_ext;

  assign sq_next = sq_reg + {d_reg, 1'b0} + (nbits+1)'(1);
  assign n_ext   = {1'b0, n_reg};

  // Moore outputs: every handshake signal is a pure function of state.
  assign istream_rdy  = (state == IDLE);
  assign div_req_val  = (state == REQ);
  assign div_resp_rdy = (state == WAIT);
  assign ostream_val  = (state == DONE);
  assign div_opa      = n_reg;
  assign div_opb      = d_reg;

  // NOTE: state registers use non-blocking assignments so every branch reads the
  // pre-edge values of n_reg/d_reg/sq_reg regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n_reg    <= '0;
      d_reg    <= '0;
      sq_reg   <= '0;
      is_prime <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            n_reg  <= num;
            d_reg  <= nbits'(2);
            sq_reg <= (nbits+1)'(4);
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (n_reg < nbits'(2)) begin
            is_prime <= 1'b0;
            state    <= DONE;
          end else if (sq_reg > n_ext) begin
            is_prime <= 1'b1;
            state    <= DONE;
          end else begin
            state <= REQ;
          end
        end
        REQ: begin
          if (div_req_rdy) state <= WAIT;
        end
        WAIT: begin
          if (div_resp_val) begin
            if (div_result == '0) begin
              is_prime <= 1'b0;
              state    <= DONE;
            end else begin
              sq_reg <= sq_next;
              d_reg  <= d_reg + nbits'(1);
              state  <= CHECK;
            end
          end
        end
        DONE: begin
          if (ostream_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_prime_seq.sv
// Directed bench for aidan_mcnay_prime_seq with a behavioural remainder unit that
// logs every request and can hold off div_req_rdy.
module tb_aidan_mcnay_prime_seq;

  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] num;
  logic          istream_val;
  logic          istream_rdy;
  logic [NB-1:0] div_opa;
  logic [NB-1:0] div_opb;
  logic          div_req_val;
  logic          div_req_rdy;
  logic [NB-1:0] div_result;
  logic          div_resp_val;
  logic          div_resp_rdy;
  logic          is_prime;
  logic          ostream_val;
  logic          ostream_rdy;

  int n_cmp = 0;
  int n_bad = 0;
  int div_stall = 0;
  logic [NB-1:0] req_opa[$];
  logic [NB-1:0] req_opb[$];

  aidan_mcnay_prime_seq #(.nbits(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .num          (num),
    .istream_val  (istream_val),
    .istream_rdy  (istream_rdy),
    .div_opa      (div_opa),
    .div_opb      (div_opb),
    .div_req_val  (div_req_val),
    .div_req_rdy  (div_req_rdy),
    .div_result   (div_result),
    .div_resp_val (div_resp_val),
    .div_resp_rdy (div_resp_rdy),
    .is_prime     (is_prime),
    .ostream_val  (ostream_val),
    .ostream_rdy  (ostream_rdy)
  );

  initial forever #5 clk = ~clk;

  // Remainder unit: runs just after each falling edge, so the values it leaves
  // behind are the ones the next rising edge samples.
  initial begin
    bit            req_fire;
    bit            resp_fire;
    int            stall_cnt;
    logic [NB-1:0] fa;
    logic [NB-1:0] fb;
    req_fire = 0; resp_fire = 0; stall_cnt = 0; fa = '0; fb = '1;
    div_req_rdy = 1'b1; div_resp_val = 1'b0; div_result = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        div_resp_val = 1'b0; div_req_rdy = 1'b1;
        req_fire = 0; resp_fire = 0; stall_cnt = 0;
      end else begin
        if (resp_fire) div_resp_val = 1'b0;
        if (req_fire) begin
          div_result   = fa % fb;
          div_resp_val = 1'b1;
        end
        if (div_req_val && stall_cnt < div_stall) begin
          div_req_rdy = 1'b0;
          stall_cnt++;
        end else begin
          div_req_rdy = 1'b1;
        end
        req_fire  = div_req_val && div_req_rdy;
        resp_fire = div_resp_val && div_resp_rdy;
        if (req_fire) begin
          fa = div_opa; fb = div_opb; stall_cnt = 0;
          req_opa.push_back(fa);
          req_opb.push_back(fb);
        end
      end
    end
  end

  task automatic send(input logic [NB-1:0] v);
    int t;
    t = 0;
    req_opa.delete(); req_opb.delete();
    num = v; istream_val = 1'b1;
    while (istream_rdy !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout num=%0d istream_rdy got %b want 1", v, istream_rdy);
    end
    @(negedge clk);
    istream_val = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (ostream_val !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    if (cyc >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout ostream_val got %b want 1", ostream_val);
    end
  endtask

  task automatic consume();
    ostream_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_candidate(input logic [NB-1:0] v, output logic verdict,
                               output int nreq, output int bad_idx);
    int c;
    send(v);
    wait_done(c);
    verdict = is_prime;
    nreq    = req_opb.size();
    bad_idx = -1;
    foreach (req_opb[i])
      if (bad_idx < 0 && (req_opa[i] !== v || req_opb[i] !== NB'(i + 2))) bad_idx = i;
    consume();
  endtask

  task automatic test_reset();
    reset = 1'b1; num = '0; istream_val = 1'b0; ostream_rdy = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({istream_rdy, div_req_val, div_resp_rdy, ostream_val, is_prime} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 10000",
               {istream_rdy, div_req_val, div_resp_rdy, ostream_val, is_prime});
    end
  endtask

  task automatic test_trivial();
    logic [NB-1:0] vals [4];
    logic          exp  [4];
    int            c;
    vals = '{16'd0, 16'd1, 16'd2, 16'd3};
    exp  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(vals[i]);
      n_cmp++;
      if (ostream_val !== 1'b0) begin
        n_bad++; $display("FAIL lat_check num=%0d ostream_val got %b want 0", vals[i], ostream_val);
      end
      @(negedge clk);
      n_cmp++;
      if (ostream_val !== 1'b1) begin
        n_bad++; $display("FAIL lat_done num=%0d ostream_val got %b want 1", vals[i], ostream_val);
      end
      wait_done(c);
      n_cmp++;
      if (is_prime !== exp[i]) begin
        n_bad++; $display("FAIL trivial_verdict num=%0d got %b want %b", vals[i], is_prime, exp[i]);
      end
      n_cmp++;
      if (req_opb.size() != 0) begin
        n_bad++; $display("FAIL trivial_reqs num=%0d got %0d want 0", vals[i], req_opb.size());
      end
      consume();
    end
  endtask

  task automatic test_divided();
    logic [NB-1:0] vals [3];
    logic          exp  [3];
    int            nexp [3];
    logic          v;
    int            nreq, bad;
    vals = '{16'd9, 16'd65535, 16'd65521};
    exp  = '{1'b0, 1'b0, 1'b1};
    nexp = '{2, 2, 254};
    for (int i = 0; i < 3; i++) begin
      run_candidate(vals[i], v, nreq, bad);
      n_cmp++;
      if (v !== exp[i]) begin
        n_bad++; $display("FAIL div_verdict num=%0d got %b want %b", vals[i], v, exp[i]);
      end
      n_cmp++;
      if (nreq != nexp[i]) begin
        n_bad++; $display("FAIL div_nreq num=%0d got %0d want %0d", vals[i], nreq, nexp[i]);
      end
      n_cmp++;
      if (bad >= 0) begin
        n_bad++;
        $display("FAIL div_seq num=%0d idx=%0d got (%0d,%0d) want (%0d,%0d)",
                 vals[i], bad, req_opa[bad], req_opb[bad], vals[i], bad + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int c;
    div_stall = 4;
    ostream_rdy = 1'b0;
    send(16'd25);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({div_req_val, div_opa, div_opb} !== {1'b1, 16'd25, 16'd2}) begin
        n_bad++;
        $display("FAIL req_hold cyc=%0d got val=%b opa=%0d opb=%0d want 1/25/2",
                 i, div_req_val, div_opa, div_opb);
      end
    end
    wait_done(c);
    div_stall = 0;
    n_cmp++;
    if (req_opb.size() != 4) begin
      n_bad++; $display("FAIL bp_nreq got %0d want 4", req_opb.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({ostream_val, is_prime, istream_rdy} !== 3'b100) begin
        n_bad++;
        $display("FAIL out_hold cyc=%0d got val/prime/irdy=%b want 100",
                 i, {ostream_val, is_prime, istream_rdy});
      end
      @(negedge clk);
    end
    consume();
    n_cmp++;
    if ({istream_rdy, ostream_val} !== 2'b10) begin
      n_bad++; $display("FAIL bp_release got irdy/oval=%b want 10", {istream_rdy, ostream_val});
    end
  endtask

  task automatic test_reset_mid();
    int   t;
    logic v;
    int   nreq, bad;
    t = 0;
    send(16'd65521);
    while (!(div_resp_rdy === 1'b1 && req_opb.size() >= 3) && t < 200) begin
      @(negedge clk); t++;
    end
    n_cmp++;
    if (t >= 200) begin
      n_bad++; $display("FAIL wait_state_timeout div_resp_rdy got %b want 1", div_resp_rdy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({istream_rdy, ostream_val, div_req_val, div_resp_rdy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_reset got irdy/oval/rval/resprdy=%b want 1000",
               {istream_rdy, ostream_val, div_req_val, div_resp_rdy});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({istream_rdy, ostream_val} !== 2'b10) begin
      n_bad++; $display("FAIL mid_reset_quiet got irdy/oval=%b want 10", {istream_rdy, ostream_val});
    end
    run_candidate(16'd7, v, nreq, bad);
    n_cmp++;
    if (v !== 1'b1 || nreq != 1 || bad >= 0) begin
      n_bad++;
      $display("FAIL after_reset num=7 got prime=%b nreq=%0d bad=%0d want 1/1/-1", v, nreq, bad);
    end
  endtask

  initial begin
    test_reset();
    test_trivial();
    test_divided();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
